// File: rtl/mips_alu_pkg.sv
// Shared definitions for the execute-stage ALU with iterative mul/div:
// ALUControl encoding, mul/div FSM state type and an op classifier.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LUI   = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_ZERO  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_MULT  = 4'b1001;
    localparam logic [3:0] ALU_MULTU = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_DIVU  = 4'b1101;
    localparam logic [3:0] ALU_MFHI  = 4'b1110;
    localparam logic [3:0] ALU_MFLO  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// Iterative multiply/divide unit with architectural HI/LO.
// Handshake: start is sampled only while IDLE; busy is high whenever the FSM
// is not IDLE; done is a one-cycle registered pulse in the cycle HI/LO first
// show the new result. Operands are captured at launch, so A/B/op may change
// freely while busy.
// Multiply: shift-add on magnitudes, product accumulates in {acc, wlo}.
// Divide: restoring, remainder in acc, dividend shifts out / quotient in wlo.
module mips_muldiv_iter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   wlo_q, wlo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [3:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod;

    // Next-state, datapath step and HI/LO commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wlo_d     = wlo_q;
        opb_d     = opb_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        signed_op = (op == ALU_MULT) || (op == ALU_DIV);
        mag_a     = (signed_op && A[WIDTH-1]) ? -A : A;
        mag_b     = (signed_op && B[WIDTH-1]) ? -B : B;
        mul_sum   = {1'b0, acc_q} + (wlo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, wlo_q[WIDTH-1]};
        // Bit WIDTH of the trial is set exactly when the divisor does not fit.
        div_trial = div_shift - {1'b0, opb_q};
        prod      = {acc_q, wlo_q};

        case (state_q)
            ST_IDLE: begin
                if (start && is_muldiv(op)) begin
                    op_d    = op;
                    cnt_d   = '0;
                    neg_a_d = signed_op & A[WIDTH-1];
                    neg_b_d = signed_op & B[WIDTH-1];
                    opb_d   = mag_b;
                    acc_d   = '0;
                    wlo_d   = mag_a;
                    if ((op == ALU_MULT) || (op == ALU_MULTU)) begin
                        state_d = ST_MUL;
                    end else if (B == '0) begin
                        // Divide by zero: preload the final answer, no fix-up.
                        acc_d   = A;
                        wlo_d   = '1;
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                acc_d = mul_sum[WIDTH:1];
                wlo_d = {mul_sum[0], wlo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                if (!div_trial[WIDTH]) begin
                    acc_d = div_trial[WIDTH-1:0];
                    wlo_d = {wlo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    wlo_d = {wlo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if ((op_q == ALU_MULT) || (op_q == ALU_MULTU)) begin
                    if (neg_a_q ^ neg_b_q) prod = -prod;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    // Quotient truncates toward zero; remainder follows dividend.
                    lo_d = (neg_a_q ^ neg_b_q) ? -wlo_q : wlo_q;
                    hi_d = neg_a_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and working/architectural registers; reset discards any op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            wlo_q   <= '0;
            opb_q   <= '0;
            op_q    <= ALU_AND;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wlo_q   <= wlo_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/mips_alu_muldiv.sv
// Execute-stage ALU: combinational logic/arithmetic ops plus an iterative
// mul/div unit with HI/LO. Control stalls on busy.
// Optional macro MIPS_ALU_OVF_EN adds a combinational Overflow output that
// flags signed overflow for ADD/SUB.
module mips_alu_muldiv
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    input  logic             start,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             busy,
    output logic             done
`ifdef MIPS_ALU_OVF_EN
    ,
    output logic             Overflow
`endif
);

    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] sum, diff;

    mips_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (ALUControl),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    assign sum  = A + B;
    assign diff = A - B;

    // Single-cycle result mux; mul/div launch codes read as zero.
    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_ADD:  Result = sum;
            ALU_SUB:  Result = diff;
            ALU_SLTU: Result = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLT:  Result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_XOR:  Result = A ^ B;
            ALU_NOR:  Result = ~(A | B);
            ALU_LUI:  Result = B << (WIDTH / 2);
            ALU_MFHI: Result = hi;
            ALU_MFLO: Result = lo;
            default:  Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

`ifdef MIPS_ALU_OVF_EN
    // Signed overflow: result sign disagrees with what the operand signs imply.
    always_comb begin
        Overflow = 1'b0;
        if (ALUControl == ALU_ADD)
            Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        else if (ALUControl == ALU_SUB)
            Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    end
`endif

endmodule
